// File: rtl/difftest_pkg.sv
// Shared constants and types for the difftest CSR delta encoder.
package difftest_pkg;

  localparam int XLEN_DEFAULT     = 64;
  localparam int MAX_CORES        = 4;
  localparam int NUM_CSRS_DEFAULT = 17;

  // Entry indices inside one snapshot; CSR_PRIV is the trailing privilege entry.
  localparam int CSR_MSTATUS  = 0;
  localparam int CSR_SSTATUS  = 1;
  localparam int CSR_MEPC     = 2;
  localparam int CSR_SEPC     = 3;
  localparam int CSR_MTVAL    = 4;
  localparam int CSR_STVAL    = 5;
  localparam int CSR_MTVEC    = 6;
  localparam int CSR_STVEC    = 7;
  localparam int CSR_MCAUSE   = 8;
  localparam int CSR_SCAUSE   = 9;
  localparam int CSR_SATP     = 10;
  localparam int CSR_MIP      = 11;
  localparam int CSR_MIE      = 12;
  localparam int CSR_MSCRATCH = 13;
  localparam int CSR_SSCRATCH = 14;
  localparam int CSR_MIDELEG  = 15;
  localparam int CSR_MEDELEG  = 16;
  localparam int CSR_PRIV     = 17;

  typedef enum logic {
    ST_IDLE,
    ST_SCAN
  } scan_state_e;

endpackage

// File: rtl/difftest_csr_delta_if.sv
// Snapshot input and delta-record output channels of the CSR delta encoder.
interface difftest_csr_delta_if #(
  parameter int NUM_CORES = 1,
  parameter int NUM_CSRS  = difftest_pkg::NUM_CSRS_DEFAULT,
  parameter int XLEN      = difftest_pkg::XLEN_DEFAULT
);
  logic [NUM_CORES-1:0]               in_valid;
  logic [NUM_CORES-1:0]               in_ready;
  logic [2*NUM_CORES-1:0]             in_priv;
  logic [NUM_CORES*NUM_CSRS*XLEN-1:0] in_csrs;
  logic                               full_dump;
  logic                               out_valid;
  logic                               out_ready;
  logic [7:0]                         out_coreid;
  logic [7:0]                         out_idx;
  logic [XLEN-1:0]                    out_data;
  logic                               out_last;

  modport master (
    output in_valid, in_priv, in_csrs, full_dump, out_ready,
    input  in_ready, out_valid, out_coreid, out_idx, out_data, out_last
  );

  modport slave (
    input  in_valid, in_priv, in_csrs, full_dump, out_ready,
    output in_ready, out_valid, out_coreid, out_idx, out_data, out_last
  );
endinterface

// File: rtl/difftest_rr_arb.sv
// Round-robin arbiter: priority starts at ptr, which moves past the winner on advance.
module difftest_rr_arb #(
  parameter int N = 1
) (
  input  logic                              io_clock,
  input  logic                              io_reset,
  input  logic [N-1:0]                      req,
  output logic [N-1:0]                      grant,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0] grant_idx,
  input  logic                              advance
);
  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] cand;

  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
    grant     = '0;
    grant_idx = ptr;
    cand      = ptr;
    // Walk from the farthest candidate back to ptr so the closest requester wins.
    for (int k = N - 1; k >= 0; k--) begin
      cand = PW'((int'(ptr) + k) % N);
      if (req[cand]) begin
        grant       = '0;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_ff @(posedge io_clock or posedge io_reset) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (io_reset) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= PW'((int'(grant_idx) + 1) % N);
    end
  end

endmodule

// File: rtl/difftest_csr_delta.sv
// Per-core CSR snapshot slots compared against shadows; changed entries leave as one record per cycle.
module difftest_csr_delta
  import difftest_pkg::*;
#(
  parameter int NUM_CORES = 1,
  parameter int NUM_CSRS  = NUM_CSRS_DEFAULT,
  parameter int XLEN      = XLEN_DEFAULT
) (
  input logic                 io_clock,
  input logic                 io_reset,
  difftest_csr_delta_if.slave io
);
  localparam int NE = NUM_CSRS + 1;
  localparam int CW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int IW = $clog2(NE);

  typedef logic [XLEN-1:0] word_t;

  word_t      slot_csrs   [NUM_CORES][NUM_CSRS];
  logic [1:0] slot_priv   [NUM_CORES];
  word_t      shadow_csrs [NUM_CORES][NUM_CSRS];
  logic [1:0] shadow_priv [NUM_CORES];

  logic [NUM_CORES-1:0] slot_full, shadow_valid, arb_req, arb_grant;
  logic [CW-1:0]        grant_idx, cur_core, src_core, rel_core;
  scan_state_e          state;
  logic [NE-1:0]        mask, diff_mask, grant_mask, src_mask;
  logic [IW-1:0]        cur_idx, nxt_idx;
  word_t                out_data_q, nxt_data;
  logic                 out_valid_q, out_last_q, nxt_last;
  logic                 granting, handshake, rel_en;

  assign arb_req   = (state == ST_IDLE) ? slot_full : '0;
  assign granting  = |arb_grant;
  assign handshake = out_valid_q & io.out_ready;

  difftest_rr_arb #(.N(NUM_CORES)) u_arb (
    .io_clock  (io_clock),
    .io_reset  (io_reset),
    .req       (arb_req),
    .grant     (arb_grant),
    .grant_idx (grant_idx),
    .advance   (granting)
  );

  function automatic logic [IW-1:0] lowest_set(input logic [NE-1:0] m);
    lowest_set = '0;
    for (int i = NE - 1; i >= 0; i--) begin
      if (m[i]) lowest_set = IW'(i);
    end
  endfunction

  // In IDLE the next record comes from the fresh grant, in SCAN from the mask minus the shown entry.
  always_comb begin
    diff_mask = '0;
    for (int i = 0; i < NUM_CSRS; i++) begin
      diff_mask[i] = slot_csrs[grant_idx][i] != shadow_csrs[grant_idx][i];
    end
    diff_mask[NUM_CSRS] = slot_priv[grant_idx] != shadow_priv[grant_idx];
    grant_mask = (!shadow_valid[grant_idx] || io.full_dump) ? '1 : diff_mask;

    src_core = (state == ST_IDLE) ? grant_idx : cur_core;
    src_mask = (state == ST_IDLE) ? grant_mask : (mask & ~(NE'(1) << cur_idx));
    nxt_idx  = lowest_set(src_mask);
    nxt_last = (src_mask & (src_mask - NE'(1))) == '0;
    nxt_data = (int'(nxt_idx) == NUM_CSRS) ? XLEN'(slot_priv[src_core])
                                           : slot_csrs[src_core][nxt_idx];

    rel_en   = ((state == ST_IDLE) && granting && (grant_mask == '0)) ||
               ((state == ST_SCAN) && handshake && out_last_q);
    rel_core = (state == ST_IDLE) ? grant_idx : cur_core;
  end

  always_ff @(posedge io_clock or posedge io_reset) begin
    if (io_reset) begin
      slot_full    <= '0;
      shadow_valid <= '0;
      state        <= ST_IDLE;
      cur_core     <= '0;
      cur_idx      <= '0;
      mask         <= '0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      out_data_q   <= '0;
    end else begin
      for (int c = 0; c < NUM_CORES; c++) begin
        if (io.in_valid[c] && !slot_full[c]) slot_full[c] <= 1'b1;
      end
      if (rel_en) begin
        slot_full[rel_core]    <= 1'b0;
        shadow_valid[rel_core] <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (granting && (grant_mask != '0)) begin
            state       <= ST_SCAN;
            cur_core    <= grant_idx;
            mask        <= grant_mask;
            out_valid_q <= 1'b1;
            cur_idx     <= nxt_idx;
            out_data_q  <= nxt_data;
            out_last_q  <= nxt_last;
          end
        end
        ST_SCAN: begin
          if (handshake) begin
            if (out_last_q) begin
              state       <= ST_IDLE;
              mask        <= '0;
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
            end else begin
              mask       <= src_mask;
              cur_idx    <= nxt_idx;
              out_data_q <= nxt_data;
              out_last_q <= nxt_last;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // NOTE: payload storage has no reset; slot_full and shadow_valid gate every use of it.
  always_ff @(posedge io_clock) begin
    for (int c = 0; c < NUM_CORES; c++) begin
      if (io.in_valid[c] && !slot_full[c]) begin
        slot_priv[c] <= io.in_priv[2*c +: 2];
        for (int i = 0; i < NUM_CSRS; i++) begin
          slot_csrs[c][i] <= io.in_csrs[(c*NUM_CSRS + i)*XLEN +: XLEN];
        end
      end
    end
    if (rel_en) begin
      shadow_csrs[rel_core] <= slot_csrs[rel_core];
      shadow_priv[rel_core] <= slot_priv[rel_core];
    end
  end

  assign io.in_ready   = ~slot_full;
  assign io.out_valid  = out_valid_q;
  assign io.out_coreid = 8'(cur_core);
  assign io.out_idx    = 8'(cur_idx);
  assign io.out_data   = out_data_q;
  assign io.out_last   = out_last_q;

endmodule
